// File: rtl/stepper_pkg.sv
// Shared types, half-step coil table and timing helpers for the 28BYJ-48 sequencer.
// Periods are in clock cycles per half-step.
package stepper_pkg;

   typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, HOLD} state_t;

   // Coil pattern {in1,in2,in3,in4} for each of the 8 half-step phases
   localparam logic [3:0] PASSOS [0:7] = '{
      4'b1000, 4'b1100, 4'b0100, 4'b0110,
      4'b0010, 4'b0011, 4'b0001, 4'b1001
   };

   function automatic int periodo_f(input int clk_hz, input int vel_hz);
      return clk_hz / vel_hz;
   endfunction

   function automatic int delta_f(input int per_max, input int per_min, input int rampa);
      return (per_max - per_min) / rampa;
   endfunction

   function automatic int hold_cyc_f(input int clk_hz, input int hold_ms);
      longint c;
      c = (longint'(hold_ms) * longint'(clk_hz)) / 1000;
      return (c < 1) ? 1 : int'(c);
   endfunction

endpackage

// File: rtl/gerador_periodo.sv
// Step-period generator: terminal-count counter plus the linear accel/decel period ramp.
// The interval after a step uses the period in force when that step issued.
module gerador_periodo #(
   parameter int PER_MAX      = 100,
   parameter int PER_MIN      = 20,
   parameter int DELTA        = 20,
   parameter int RAMPA_PASSOS = 4,
   localparam int PER_W       = $clog2(PER_MAX + 1),
   localparam int RAMPA_W     = $clog2(RAMPA_PASSOS + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               run_i,
   input  logic               acelera_i,
   input  logic               desacelera_i,
   output logic               passo_tick_o,
   output logic [RAMPA_W-1:0] rampa_cnt_o,
   output logic               per_min_o
);

   localparam logic [PER_W-1:0]   PMAX   = PER_W'(PER_MAX);
   localparam logic [PER_W-1:0]   PMIN   = PER_W'(PER_MIN);
   localparam logic [PER_W-1:0]   PDELTA = PER_W'(DELTA);
   localparam logic [RAMPA_W-1:0] RMAX   = RAMPA_W'(RAMPA_PASSOS);

   logic [PER_W-1:0]   per_q, per_d, cnt_q, cnt_d;
   logic [RAMPA_W-1:0] rampa_q, rampa_d;

   assign passo_tick_o = run_i && (cnt_q == '0);
   assign rampa_cnt_o  = rampa_q;
   assign per_min_o    = (per_q == PMIN);

   always_comb begin
      per_d   = per_q;
      cnt_d   = cnt_q;
      rampa_d = rampa_q;
      if (load_i) begin
         // cnt=0 makes the first step issue on the cycle right after accept
         per_d   = PMAX;
         cnt_d   = '0;
         rampa_d = '0;
      end else if (run_i) begin
         if (cnt_q == '0) begin
            cnt_d = per_q - PER_W'(1);
            if (acelera_i) begin
               per_d = (per_q >= PMIN + PDELTA) ? per_q - PDELTA : PMIN;
               if (rampa_q != RMAX) rampa_d = rampa_q + RAMPA_W'(1);
            end else if (desacelera_i) begin
               per_d = (per_q <= PMAX - PDELTA) ? per_q + PDELTA : PMAX;
               if (rampa_q != '0) rampa_d = rampa_q - RAMPA_W'(1);
            end
         end else begin
            cnt_d = cnt_q - PER_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         per_q   <= PMAX;
         cnt_q   <= '0;
         rampa_q <= '0;
      end else begin
         per_q   <= per_d;
         cnt_q   <= cnt_d;
         rampa_q <= rampa_d;
      end
   end

endmodule

// File: rtl/stepper_sequenciador.sv
// Command-driven half-step sequencer for the 28BYJ-48 / ULN2003: move FSM, step count,
// phase index and coil hold/release. Step timing comes from gerador_periodo.
module stepper_sequenciador
   import stepper_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 25_000_000,
   parameter int VEL_MIN_HZ   = 250,
   parameter int VEL_MAX_HZ   = 1000,
   parameter int RAMPA_PASSOS = 64,
   parameter int HOLD_MS      = 20,
   parameter int STEPS_W      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [STEPS_W-1:0] cmd_passos_i,
   input  logic               cmd_dir_i,
   input  logic               abort_i,
   output logic [3:0]         bobinas_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               abortado_o,
   output logic [STEPS_W-1:0] passos_restantes_o
);

   localparam int PER_MAX  = periodo_f(CLK_FREQ_HZ, VEL_MIN_HZ);
   localparam int PER_MIN  = periodo_f(CLK_FREQ_HZ, VEL_MAX_HZ);
   localparam int DELTA    = delta_f(PER_MAX, PER_MIN, RAMPA_PASSOS);
   localparam int HOLD_CYC = hold_cyc_f(CLK_FREQ_HZ, HOLD_MS);
   localparam int HOLD_W   = $clog2(HOLD_CYC + 1);
   localparam int RAMPA_W  = $clog2(RAMPA_PASSOS + 1);

   state_t               state_q, state_d;
   logic [STEPS_W-1:0]   passos_q, passos_d;
   logic [2:0]           phase_q, phase_d;
   logic                 dir_q, dir_d;
   logic                 abortado_q, abortado_d;
   logic                 done_q, done_d;
   logic [3:0]           bob_q, bob_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic                 moving, accept, load, tick, per_min;
   logic [RAMPA_W-1:0]   rampa_cnt;

   assign moving      = (state_q == ACCEL) || (state_q == CRUISE) || (state_q == DECEL);
   assign cmd_ready_o = rst_n && (state_q == IDLE);
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign load        = accept && (cmd_passos_i != '0);

   gerador_periodo #(
      .PER_MAX      (PER_MAX),
      .PER_MIN      (PER_MIN),
      .DELTA        (DELTA),
      .RAMPA_PASSOS (RAMPA_PASSOS)
   ) u_gerador (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (load),
      .run_i        (moving),
      .acelera_i    (state_q == ACCEL),
      .desacelera_i (state_q == DECEL),
      .passo_tick_o (tick),
      .rampa_cnt_o  (rampa_cnt),
      .per_min_o    (per_min)
   );

   always_comb begin
      state_d    = state_q;
      passos_d   = passos_q;
      phase_d    = phase_q;
      dir_d      = dir_q;
      abortado_d = done_q ? 1'b0 : abortado_q;
      done_d     = 1'b0;
      bob_d      = bob_q;
      hold_d     = hold_q;
      case (state_q)
         IDLE: begin
            bob_d = '0;
            if (accept) begin
               abortado_d = 1'b0;
               passos_d   = cmd_passos_i;
               dir_d      = cmd_dir_i;
               if (cmd_passos_i == '0) done_d = 1'b1;
               else                    state_d = ACCEL;
            end
         end
         ACCEL, CRUISE, DECEL: begin
            if (tick) begin
               phase_d  = dir_q ? phase_q + 3'd1 : phase_q - 3'd1;
               passos_d = passos_q - STEPS_W'(1);
               bob_d    = PASSOS[phase_d];
            end
            // Enough steps left only to ramp back down: start decelerating
            if (state_q != DECEL && 32'(passos_q) <= 32'(rampa_cnt)) state_d = DECEL;
            else if (state_q == ACCEL && per_min)                     state_d = CRUISE;
            if (abort_i || passos_d == '0) begin
               state_d = HOLD;
               hold_d  = HOLD_W'(HOLD_CYC - 1);
               if (abort_i) abortado_d = 1'b1;
            end
         end
         HOLD: begin
            if (hold_q == '0) begin
               state_d = IDLE;
               bob_d   = '0;
               done_d  = 1'b1;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         passos_q   <= '0;
         phase_q    <= '0;
         dir_q      <= 1'b0;
         abortado_q <= 1'b0;
         done_q     <= 1'b0;
         bob_q      <= '0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         passos_q   <= passos_d;
         phase_q    <= phase_d;
         dir_q      <= dir_d;
         abortado_q <= abortado_d;
         done_q     <= done_d;
         bob_q      <= bob_d;
         hold_q     <= hold_d;
      end
   end

   assign bobinas_o          = bob_q;
   assign busy_o             = moving || (state_q == HOLD);
   assign done_o             = done_q;
   assign abortado_o         = abortado_q;
   assign passos_restantes_o = passos_q;

endmodule

// File: tb/tb_stepper_sequenciador.sv
// Directed bench for stepper_sequenciador at 1 kHz / 10..50 steps/s / 4-step ramp / 10-cycle hold.
// Step times are offsets in cycles from the accepting clock edge.
module tb_stepper_sequenciador;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_passos;
   logic        cmd_dir;
   logic        abort;
   logic [3:0]  bobinas;
   logic        busy;
   logic        done;
   logic        abortado;
   logic [15:0] passos_restantes;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int base   = 0;
   int ph     = 0;

   // Half-step table and the 20-step profile: intervals 100,80,60,40, cruise 20, decel 20,40,60
   logic [3:0] PAT [0:7] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                             4'b0010, 4'b0011, 4'b0001, 4'b1001};
   int OFF20 [0:19] = '{1, 101, 181, 241, 281, 301, 321, 341, 361, 381,
                        401, 421, 441, 461, 481, 501, 521, 541, 581, 641};

   stepper_sequenciador #(
      .CLK_FREQ_HZ  (1000),
      .VEL_MIN_HZ   (10),
      .VEL_MAX_HZ   (50),
      .RAMPA_PASSOS (4),
      .HOLD_MS      (10),
      .STEPS_W      (16)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .cmd_valid_i        (cmd_valid),
      .cmd_ready_o        (cmd_ready),
      .cmd_passos_i       (cmd_passos),
      .cmd_dir_i          (cmd_dir),
      .abort_i            (abort),
      .bobinas_o          (bobinas),
      .busy_o             (busy),
      .done_o             (done),
      .abortado_o         (abortado),
      .passos_restantes_o (passos_restantes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for the coil pattern to change, then check new pattern and its time
   task automatic expect_step(input string tag, input int exp_off, input logic [3:0] exp_pat);
      logic [3:0] prev;
      int n;
      prev = bobinas;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bobinas === prev && n < 200);
      chk({tag, " pattern"}, {28'd0, bobinas}, {28'd0, exp_pat});
      chk({tag, " time"}, cyc - base, exp_off);
   endtask

   // Offer a command at a negedge; returns at the negedge after the accepting edge
   task automatic send(input int n, input logic d, input logic keep);
      cmd_passos = 16'(n);
      cmd_dir    = d;
      cmd_valid  = 1'b1;
      base       = cyc + 1;
      @(negedge clk);
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic walk(input string tag, input int nsteps, input logic d);
      for (int k = 0; k < nsteps; k++) begin
         ph = d ? (ph + 1) % 8 : (ph + 7) % 8;
         expect_step($sformatf("%s step%0d", tag, k + 1), OFF20[k], PAT[ph]);
      end
   endtask

   task automatic do_reset(input string tag);
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      repeat (2) @(negedge clk);
      chk({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
      chk({tag, " bobinas"}, {28'd0, bobinas}, 32'd0);
      chk({tag, " busy"}, {31'd0, busy}, 32'd0);
      chk({tag, " done"}, {31'd0, done}, 32'd0);
      chk({tag, " abortado"}, {31'd0, abortado}, 32'd0);
      chk({tag, " passos"}, {16'd0, passos_restantes}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk({tag, " ready after"}, {31'd0, cmd_ready}, 32'd1);
      ph = 0;
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_passos = '0; cmd_dir = 1'b0; abort = 1'b0;
      do_reset("RST");

      // T1: 20 steps forward, full trapezoid
      send(20, 1'b1, 1'b0);
      chk("T1 accepted busy", {31'd0, busy}, 32'd1);
      chk("T1 ready low", {31'd0, cmd_ready}, 32'd0);
      chk("T1 passos latched", {16'd0, passos_restantes}, 32'd20);
      walk("T1", 20, 1'b1);
      chk("T1 passos zero", {16'd0, passos_restantes}, 32'd0);
      chk("T1 busy in hold", {31'd0, busy}, 32'd1);
      expect_step("T1 release", 651, 4'b0000);
      chk("T1 done", {31'd0, done}, 32'd1);
      chk("T1 abortado", {31'd0, abortado}, 32'd0);
      chk("T1 busy end", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("T1 done pulse", {31'd0, done}, 32'd0);
      $display("T1 20 steps dir=1 finished");

      do_reset("RST2");

      // T2: short 3-step move backwards, triangle profile
      send(3, 1'b0, 1'b0);
      ph = 7; expect_step("T2 step1", 1, 4'b1001);
      ph = 6; expect_step("T2 step2", 101, 4'b0001);
      ph = 5; expect_step("T2 step3", 181, 4'b0011);
      expect_step("T2 release", 191, 4'b0000);
      chk("T2 done", {31'd0, done}, 32'd1);
      chk("T2 abortado", {31'd0, abortado}, 32'd0);
      $display("T2 3 steps dir=0 finished");

      // T3: abort in cruise after 6 steps (phase 5 -> 3)
      send(20, 1'b1, 1'b0);
      walk("T3", 6, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      chk("T3 abortado set", {31'd0, abortado}, 32'd1);
      chk("T3 busy hold", {31'd0, busy}, 32'd1);
      chk("T3 passos frozen", {16'd0, passos_restantes}, 32'd14);
      abort = 1'b0;
      expect_step("T3 release", 312, 4'b0000);
      chk("T3 done", {31'd0, done}, 32'd1);
      chk("T3 abortado with done", {31'd0, abortado}, 32'd1);
      chk("T3 passos after", {16'd0, passos_restantes}, 32'd14);
      @(negedge clk);
      chk("T3 done pulse", {31'd0, done}, 32'd0);
      $display("T3 abort in cruise finished");

      // T4: zero-step command
      send(0, 1'b1, 1'b0);
      chk("T4 done", {31'd0, done}, 32'd1);
      chk("T4 abortado", {31'd0, abortado}, 32'd0);
      chk("T4 bobinas", {28'd0, bobinas}, 32'd0);
      chk("T4 ready", {31'd0, cmd_ready}, 32'd1);
      chk("T4 busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("T4 done pulse", {31'd0, done}, 32'd0);
      $display("T4 zero-step command finished");

      // T5: reset in the middle of acceleration (phase 3 -> 4 then reset)
      send(10, 1'b1, 1'b0);
      ph = 4; expect_step("T5 step1", 1, 4'b0010);
      repeat (49) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("T5 bobinas", {28'd0, bobinas}, 32'd0);
      chk("T5 ready", {31'd0, cmd_ready}, 32'd0);
      chk("T5 busy", {31'd0, busy}, 32'd0);
      chk("T5 done", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("T5 done still", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("T5 ready after", {31'd0, cmd_ready}, 32'd1);
      ph = 0;
      $display("T5 reset mid-accel finished");

      // T6: cmd_valid held high, two back-to-back 2-step moves, phases 1..4
      send(2, 1'b1, 1'b1);
      expect_step("T6a step1", 1, 4'b1100);
      expect_step("T6a step2", 101, 4'b0100);
      expect_step("T6a release", 111, 4'b0000);
      chk("T6a done", {31'd0, done}, 32'd1);
      chk("T6a ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      chk("T6b accepted", {31'd0, busy}, 32'd1);
      chk("T6b ready low", {31'd0, cmd_ready}, 32'd0);
      chk("T6b done clear", {31'd0, done}, 32'd0);
      chk("T6b passos", {16'd0, passos_restantes}, 32'd2);
      expect_step("T6b step1", 113, 4'b0110);
      expect_step("T6b step2", 213, 4'b0010);
      expect_step("T6b release", 223, 4'b0000);
      chk("T6b done", {31'd0, done}, 32'd1);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("T6 idle after", {31'd0, busy}, 32'd0);
      chk("T6 ready after", {31'd0, cmd_ready}, 32'd1);
      $display("T6 back-to-back moves finished");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
